// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and saturating-counter helpers for the branch predictor
package branch_predictor_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Largest value a w-bit counter can hold
    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Increment, sticking at the top value
    function automatic int ctr_inc_sat(input int v, input int w);
        return (v >= ctr_max(w)) ? v : v + 1;
    endfunction

    // Decrement, sticking at zero
    function automatic int ctr_dec_sat(input int v);
        return (v <= 0) ? 0 : v - 1;
    endfunction

    // Weakly-not-taken: just below the taken threshold
    function automatic int ctr_weak_nt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Weakly-taken: the taken threshold itself
    function automatic int ctr_weak_t(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - direction counter array with async read and saturating write
module bp_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CTR_WIDTH = 2,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CTR_WIDTH-1:0] rd_ctr,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_taken
);

    localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] ctr [ENTRIES];
    logic [CTR_WIDTH-1:0] wr_val;

    // Read port sees the registered value, so a same-cycle write is invisible (read-old)
    assign rd_ctr = ctr[rd_idx];

    // Next value of the entry being trained, saturating at both ends
    always_comb begin
        wr_val = ctr[wr_idx];
        if (wr_taken) begin
            wr_val = CTR_WIDTH'(ctr_inc_sat(int'(ctr[wr_idx]), CTR_WIDTH));
        end else begin
            wr_val = CTR_WIDTH'(ctr_dec_sat(int'(ctr[wr_idx])));
        end
    end

    // Counter storage; reset puts every entry at weakly-not-taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= WEAK_NT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_val;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare direction predictor with a direct-mapped tagged BTB
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 64,
    parameter int CTR_WIDTH  = 2,
    parameter int TAG_WIDTH  = 8,
    parameter int MODE       = 0,
    parameter int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lkValid,
    input  logic [ADDR_WIDTH-1:0] lkPc,
    output logic                  predTaken,
    output logic [ADDR_WIDTH-1:0] predTarget,
    output logic [IDX_W-1:0]      predGhr,
    input  logic                  updValid,
    input  logic [ADDR_WIDTH-1:0] updPc,
    input  logic [IDX_W-1:0]      updGhr,
    input  logic                  updTaken,
    input  logic [ADDR_WIDTH-1:0] updTarget,
    input  logic                  updMispredict
);

    logic [ENTRIES-1:0]    btb_valid;
    logic [TAG_WIDTH-1:0]  btb_tag [ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_tgt [ENTRIES];

    logic [IDX_W-1:0]     ghr;
    logic [IDX_W-1:0]     lk_bi, lk_ci, upd_bi, upd_ci;
    logic [TAG_WIDTH-1:0] lk_tag, upd_tag;
    logic [CTR_WIDTH-1:0] lk_ctr;
    logic                 lk_hit;
    logic                 unused_bits;

    assign lk_bi   = lkPc[IDX_W-1:0];
    assign lk_tag  = lkPc[IDX_W+TAG_WIDTH-1:IDX_W];
    assign upd_bi  = updPc[IDX_W-1:0];
    assign upd_tag = updPc[IDX_W+TAG_WIDTH-1:IDX_W];

    // Lookup hashes with the live history; training uses the history the branch saw at fetch
    assign lk_ci  = lk_bi ^ ghr;
    assign upd_ci = upd_bi ^ ((MODE == BP_MODE_GSHARE) ? updGhr : '0);

    // High PC bits and, in bimodal mode, the history/mispredict inputs play no part
    assign unused_bits = ^{updPc, updGhr, updMispredict};

    bp_counter_table #(
        .ENTRIES   (ENTRIES),
        .CTR_WIDTH (CTR_WIDTH),
        .IDX_W     (IDX_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lk_ci),
        .rd_ctr   (lk_ctr),
        .wr_en    (updValid),
        .wr_idx   (upd_ci),
        .wr_taken (updTaken)
    );

    // Combinational prediction; BTB valid bits are cleared under reset so no hit can leak out
    always_comb begin
        lk_hit     = btb_valid[lk_bi] && (btb_tag[lk_bi] == lk_tag);
        predTaken  = lkValid && lk_hit && lk_ctr[CTR_WIDTH-1];
        predTarget = predTaken ? btb_tgt[lk_bi] : lkPc + ADDR_WIDTH'(1);
        predGhr    = ghr;
    end

    // BTB valid bits: allocate on every resolved taken branch, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (updValid && updTaken) begin
            btb_valid[upd_bi] <= 1'b1;
        end
    end

    // BTB tag/target payload; only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (rst && updValid && updTaken) begin
            btb_tag[upd_bi] <= upd_tag;
            btb_tgt[upd_bi] <= updTarget;
        end
    end

    generate
        if (MODE == BP_MODE_GSHARE) begin : g_ghr
            // History: recovery on mispredict beats the speculative shift of a flushed fetch
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ghr <= '0;
                end else if (updValid && updMispredict) begin
                    ghr <= {updGhr[IDX_W-2:0], updTaken};
                end else if (lkValid && lk_hit) begin
                    ghr <= {ghr[IDX_W-2:0], predTaken};
                end
            end
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

endmodule
